instmem_prog: RTL

Programmable, parametrised instruction memory for the ARM pipeline IF stage, replacing the fixed combinational ROM. Program words are streamed in through a loader handshake after reset. The IF stage then fetches through a request/valid port with configurable read latency. Words at or beyond the loaded count, and out-of-range addresses, return `NOP_WORD`, so partially loaded programs run safely.

---
 rtl/instmem_prog_pkg.sv | 18 +
 rtl/instmem_prog_if.sv | 34 +++
 rtl/instmem_prog_rd_pipe.sv | 51 +++++
 rtl/instmem_prog.sv | 117 +++++++++++
 4 files changed

// File: rtl/instmem_prog_pkg.sv
// Shared definitions for the programmable instruction memory: FSM state
// encoding, default NOP word and the word-index width helper.
package arm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  // Number of bits needed to index a word array of the given depth.
  function automatic int word_idx_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/instmem_prog_if.sv
// Loader and fetch bus of the instruction memory.
//
// Handshakes: a loader word transfers on a rising clock edge where
// ld_valid & ld_ready are both high; ld_data/ld_last are only meaningful
// while ld_valid is high. A fetch is accepted on an edge where
// f_req & f_ready are both high; f_valid is a one-cycle pulse per accepted
// fetch, has no backpressure, and f_data/f_err hold while f_valid is low.
interface instmem_prog_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              ld_start;
  logic              ld_valid;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ovf;
  logic              f_ready;
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_valid;
  logic [DATA_W-1:0] f_data;
  logic              f_err;

  modport master (
    output ld_start, ld_valid, ld_data, ld_last, f_req, f_addr,
    input  ld_ready, ld_ovf, f_ready, f_valid, f_data, f_err
  );

  modport slave (
    input  ld_start, ld_valid, ld_data, ld_last, f_req, f_addr,
    output ld_ready, ld_ovf, f_ready, f_valid, f_data, f_err
  );
endinterface

// File: rtl/instmem_prog_rd_pipe.sv
// Fixed-latency read pipeline: LAT-deep shift register of valid/data/err.
// Data stages only load when their upstream valid is set, so the output
// holds its last value between valid pulses.
module rd_pipe #(
  parameter int          LAT      = 1,
  parameter int          W        = 32,
  parameter logic [W-1:0] RST_DATA = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  input  logic         i_err,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_err
);

  logic         r_v [LAT];
  logic [W-1:0] r_d [LAT];
  logic         r_e [LAT];

  // Shift valid every cycle; move data/err forward only with a valid beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LAT; k++) begin
        r_v[k] <= 1'b0;
        r_d[k] <= RST_DATA;
        r_e[k] <= 1'b0;
      end
    end else begin
      r_v[0] <= i_valid;
      if (i_valid) begin
        r_d[0] <= i_data;
        r_e[0] <= i_err;
      end
      for (int k = 1; k < LAT; k++) begin
        r_v[k] <= r_v[k-1];
        if (r_v[k-1]) begin
          r_d[k] <= r_d[k-1];
          r_e[k] <= r_e[k-1];
        end
      end
    end
  end

  assign o_valid = r_v[LAT-1];
  assign o_data  = r_d[LAT-1];
  assign o_err   = r_e[LAT-1];

endmodule

// File: rtl/instmem_prog.sv
// Programmable instruction memory for the IF stage. Words are streamed in
// through the loader port, then fetched with a fixed RD_LAT latency.
// Unloaded words read as NOP_WORD; misaligned/out-of-range reads also flag
// f_err.
module instmem_prog
  import arm_pkg::*;
#(
  parameter int               ADDR_W   = 32,
  parameter int               DATA_W   = 32,
  parameter int               DEPTH    = 256,
  parameter int               RD_LAT   = 1,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  instmem_prog_if.slave          bus,
  output state_t                 o_dbg_state,
  output logic [$clog2(DEPTH):0] o_dbg_count
);

  localparam int IW = word_idx_w(DEPTH);

  state_t            r_state;
  state_t            w_state_nxt;
  // Write pointer and loaded-word count always advance together, so a
  // single register serves both; its MSB set means the array is full.
  logic [IW:0]       r_count;
  logic              r_ovf;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_xfer;
  logic              w_wr;
  logic              w_acc;
  logic [IW-1:0]     w_idx;
  logic              w_mis;
  logic              w_oor;
  logic              w_unl;
  logic              w_err;
  logic [DATA_W-1:0] w_rd_data;

  assign bus.ld_ready = (r_state == ST_LOAD);
  assign bus.f_ready  = (r_state == ST_RUN);
  assign bus.ld_ovf   = r_ovf;

  // A restart pulse wins over a transfer in the same cycle.
  assign w_xfer = bus.ld_valid & bus.ld_ready & ~bus.ld_start;
  assign w_wr   = w_xfer & ~r_count[IW];

  // Leaving RUN on ld_start also refuses that cycle's fetch.
  assign w_acc  = bus.f_req & bus.f_ready & ~bus.ld_start;

  assign w_idx     = bus.f_addr[IW+1:2];
  assign w_mis     = |bus.f_addr[1:0];
  assign w_oor     = (bus.f_addr >> (IW + 2)) != '0;
  assign w_err     = w_mis | w_oor;
  assign w_unl     = {1'b0, w_idx} >= r_count;
  assign w_rd_data = (w_err | w_unl) ? NOP_WORD : r_mem[w_idx];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: load on start, run after the last word.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.ld_start) w_state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (bus.ld_start)                 w_state_nxt = ST_LOAD;
        else if (w_xfer && bus.ld_last)   w_state_nxt = ST_RUN;
      end
      ST_RUN:  if (bus.ld_start) w_state_nxt = ST_LOAD;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Loaded count and sticky overflow; a start pulse clears both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (bus.ld_start) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (w_wr) begin
      r_count <= r_count + 1'b1;
    end else if (w_xfer) begin
      r_ovf   <= 1'b1;
    end
  end

  // Array write; contents survive reset, count gates what is visible.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_count[IW-1:0]] <= bus.ld_data;
  end

  rd_pipe #(
    .LAT      (RD_LAT),
    .W        (DATA_W),
    .RST_DATA (NOP_WORD)
  ) u_rd_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_acc),
    .i_data  (w_rd_data),
    .i_err   (w_err),
    .o_valid (bus.f_valid),
    .o_data  (bus.f_data),
    .o_err   (bus.f_err)
  );

  assign o_dbg_state = r_state;
  assign o_dbg_count = r_count;

endmodule
